// File: rtl/freq_meter_multi.sv
// N-channel gated frequency meter: counts synchronised rising edges per gate window, scales to Hz.
// Define FREQ_AVG_EN to report a 4-window running average instead of the single-window result.
module freq_meter_multi #(
  parameter int NUM_CH           = 4,
  parameter int CNT_W            = 32,
  parameter int BASE_GATE_CYCLES = 20000000,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        pulse_in,
  input  logic [1:0]               gate_sel,
  output logic [NUM_CH*CNT_W-1:0]  freq_out,
  output logic                     freq_valid,
  output logic [NUM_CH-1:0]        overflow
);
  localparam int GATE_W = $clog2(BASE_GATE_CYCLES);
  localparam int PROD_W = CNT_W + 10;
  localparam int SUM_W  = CNT_W + 2;

  logic [GATE_W-1:0] r_gate_cnt;
  logic [1:0]        r_sel;
  logic              r_valid;
  logic [1:0]        w_sel;
  logic [GATE_W-1:0] w_gl_m1;
  logic [9:0]        w_scale;
  logic              w_term;

  // gate_sel is live in the first cycle of a window and latched for the rest of it
  always_comb begin
    w_sel   = (r_gate_cnt == '0) ? gate_sel : r_sel;
    w_gl_m1 = GATE_W'(BASE_GATE_CYCLES - 1);
    w_scale = 10'd1;
    case (w_sel)
      2'd1: begin w_gl_m1 = GATE_W'(BASE_GATE_CYCLES / 10 - 1);   w_scale = 10'd10;   end
      2'd2: begin w_gl_m1 = GATE_W'(BASE_GATE_CYCLES / 100 - 1);  w_scale = 10'd100;  end
      2'd3: begin w_gl_m1 = GATE_W'(BASE_GATE_CYCLES / 1000 - 1); w_scale = 10'd1000; end
      default: ;
    endcase
    w_term = (r_gate_cnt == w_gl_m1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gate_cnt <= '0;
      r_sel      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_term;
      if (r_gate_cnt == '0) r_sel <= gate_sel;
      r_gate_cnt <= w_term ? '0 : r_gate_cnt + GATE_W'(1);
    end
  end

  assign freq_valid = r_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_prev;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_sat;
      logic [CNT_W-1:0]       r_freq;
      logic                   r_ovf;
      logic                   w_edge;
      logic [CNT_W-1:0]       w_cnt_next;
      logic                   w_sat_next;
      logic [PROD_W-1:0]      w_prod;
      logic                   w_prod_ovf;
      logic [CNT_W-1:0]       w_res;
      logic                   w_res_ovf;

      assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

      // Final count includes an edge landing in the terminal cycle
      always_comb begin
        w_cnt_next = r_cnt;
        w_sat_next = r_sat;
        if (w_edge) begin
          if (&r_cnt) w_sat_next = 1'b1;
          else        w_cnt_next = r_cnt + CNT_W'(1);
        end
        w_prod     = PROD_W'(w_cnt_next) * PROD_W'(w_scale);
        w_prod_ovf = |w_prod[PROD_W-1:CNT_W];
        w_res      = w_prod_ovf ? '1 : w_prod[CNT_W-1:0];
        w_res_ovf  = w_sat_next | w_prod_ovf;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '0;
          r_prev <= 1'b0;
          r_cnt  <= '0;
          r_sat  <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in[gi]};
          r_prev <= r_sync[SYNC_STAGES-1];
          if (w_term) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
          end else begin
            r_cnt <= w_cnt_next;
            r_sat <= w_sat_next;
          end
        end
      end

`ifdef FREQ_AVG_EN
      // Three previous results plus the one being closed form the 4-window history
      logic [CNT_W-1:0] r_hist [3];
      logic [2:0]       r_hist_ovf;
      logic [SUM_W-1:0] w_sum;

      assign w_sum = SUM_W'(w_res) + SUM_W'(r_hist[0]) + SUM_W'(r_hist[1]) + SUM_W'(r_hist[2]);

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < 3; k++) r_hist[k] <= '0;
          r_hist_ovf <= '0;
          r_freq     <= '0;
          r_ovf      <= 1'b0;
        end else if (w_term) begin
          r_hist[0]  <= w_res;
          r_hist[1]  <= r_hist[0];
          r_hist[2]  <= r_hist[1];
          r_hist_ovf <= {r_hist_ovf[1:0], w_res_ovf};
          r_freq     <= w_sum[SUM_W-1:2];
          r_ovf      <= w_res_ovf | (|r_hist_ovf);
        end
      end
`else
      always_ff @(posedge clk) begin
        if (rst) begin
          r_freq <= '0;
          r_ovf  <= 1'b0;
        end else if (w_term) begin
          r_freq <= w_res;
          r_ovf  <= w_res_ovf;
        end
      end
`endif

      assign freq_out[gi*CNT_W +: CNT_W] = r_freq;
      assign overflow[gi]                = r_ovf;
    end
  endgenerate

endmodule

// File: tb/tb_freq_meter_multi.sv
// Bench for freq_meter_multi: window-level model checked every cycle, plus directed literal checks.
module tb_freq_meter_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;
  localparam int BASE   = 20000;
  localparam int SYNC   = 2;
  localparam longint MAXV = (64'd1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       pulse_in = '0;
  logic [1:0]              gate_sel = 2'd3;
  logic [NUM_CH*CNT_W-1:0] freq_out;
  logic                    freq_valid;
  logic [NUM_CH-1:0]       overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int n_cyc_fail = 0;

  freq_meter_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BASE_GATE_CYCLES(BASE), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .gate_sel(gate_sel),
    .freq_out(freq_out), .freq_valid(freq_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Square-wave generators: period in clk cycles, 0 = tied low; restart low on reprogramming
  int per [NUM_CH] = '{default: 0};
  int ph  [NUM_CH] = '{default: 0};
  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (per[c] == 0) begin
        ph[c] = 0;
        pulse_in[c] = 1'b0;
      end else begin
        ph[c] = (ph[c] + 1) % per[c];
        pulse_in[c] = (ph[c] >= per[c] / 2);
      end
    end
  end

  task automatic set_period(input int c, input int p);
    per[c] = p;
    ph[c]  = 0;
  endtask

  // Model: a rising pin sample is seen SYNC+1 edges later; counts are unbounded and clipped at window close
  int     m_pos = 0;
  int     m_gl  = BASE / 1000;
  longint m_scale = 1000;
  longint m_cnt [NUM_CH];
  bit     m_hist [NUM_CH][SYNC+1];
  longint m_rq [NUM_CH][4];
  bit     m_oq [NUM_CH][4];
  logic [NUM_CH*CNT_W-1:0] exp_freq = '0;
  logic [NUM_CH-1:0]       exp_ovf  = '0;
  logic                    exp_valid = 1'b0;

  function automatic longint gate_div(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 10;
      2'd2: return 100;
      default: return 1000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0;
      exp_valid = 1'b0;
      exp_freq = '0;
      exp_ovf = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_cnt[c] = 0;
        for (int j = 0; j <= SYNC; j++) m_hist[c][j] = 1'b0;
        for (int j = 0; j < 4; j++) begin m_rq[c][j] = 0; m_oq[c][j] = 1'b0; end
      end
    end else begin
      if (m_pos == 0) begin
        m_scale = gate_div(gate_sel);
        m_gl = BASE / int'(m_scale);
      end
      exp_valid = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_hist[c][SYNC-1] && !m_hist[c][SYNC]) m_cnt[c]++;
        for (int j = SYNC; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
        m_hist[c][0] = pulse_in[c];
      end
      if (m_pos == m_gl - 1) begin
        for (int c = 0; c < NUM_CH; c++) begin
          longint cc, prod, r;
          bit sat, po, ov;
          cc   = m_cnt[c];
          sat  = cc > MAXV;
          if (sat) cc = MAXV;
          prod = cc * m_scale;
          po   = prod > MAXV;
          r    = po ? MAXV : prod;
          ov   = sat | po;
`ifdef FREQ_AVG_EN
          for (int j = 3; j > 0; j--) begin m_rq[c][j] = m_rq[c][j-1]; m_oq[c][j] = m_oq[c][j-1]; end
          m_rq[c][0] = r;
          m_oq[c][0] = ov;
          r  = (m_rq[c][0] + m_rq[c][1] + m_rq[c][2] + m_rq[c][3]) >> 2;
          ov = m_oq[c][0] | m_oq[c][1] | m_oq[c][2] | m_oq[c][3];
`endif
          exp_freq[c*CNT_W +: CNT_W] = r[CNT_W-1:0];
          exp_ovf[c] = ov;
          m_cnt[c] = 0;
        end
        exp_valid = 1'b1;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    n_checks++;
    if (freq_valid === exp_valid && freq_out === exp_freq && overflow === exp_ovf) begin
      n_pass++;
    end else begin
      if (n_cyc_fail < 20)
        $display("FAIL cycle_compare t=%0t: valid=%b freq=%h ovf=%b, required valid=%b freq=%h ovf=%b",
                 $time, freq_valid, freq_out, overflow, exp_valid, exp_freq, exp_ovf);
      n_cyc_fail++;
    end
  end

  function automatic logic [CNT_W-1:0] f(input int c);
    return freq_out[c*CNT_W +: CNT_W];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic chk2(input string name, input logic [63:0] act, input logic [63:0] a, input logic [63:0] b);
    n_checks++;
    if (act === a || act === b) n_pass++;
    else $display("FAIL %s: got %0d, required %0d or %0d", name, act, a, b);
  endtask

  task automatic wait_valid(input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (freq_valid !== 1'b1 && waited < limit);
    if (freq_valid !== 1'b1) begin
      n_checks++;
      $display("FAIL wait_valid: no freq_valid within %0d cycles", limit);
    end else begin
      $display("window after %0d cycles: f0=%0d f1=%0d f2=%0d f3=%0d ovf=%b",
               waited, f(0), f(1), f(2), f(3), overflow);
    end
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("reset_freq_out", 64'(freq_out), 0);
    chk("reset_overflow", 64'(overflow), 0);
    chk("reset_valid", 64'(freq_valid), 0);

    // gate_sel=3: GL=20 cycles, scale 1000
    set_period(0, 8);
    set_period(1, 4);
    set_period(2, 20);
    set_period(3, 0);
    rst = 1'b0;
    wait_valid(100, w);
    chk("first_valid_latency", w, 20);
`ifdef FREQ_AVG_EN
    chk("avg_ramp_1", 64'(f(2)), 250);
    for (int k = 2; k <= 4; k++) begin
      wait_valid(100, w);
      chk($sformatf("avg_ramp_%0d", k), 64'(f(2)), 250 * k);
    end
`else
    chk("win1_ch2", 64'(f(2)), 1000);
    wait_valid(100, w);
    chk("win_period", w, 20);
    chk2("win2_ch0", 64'(f(0)), 2000, 3000);
    chk("win2_ch1_sat", 64'(f(1)), MAXV);
    chk("win2_ch1_ovf", 64'(overflow[1]), 1);
    chk("win2_ch2", 64'(f(2)), 1000);
    chk("win2_ch3", 64'(f(3)), 0);
    chk("win2_ovf_others", 64'({overflow[3:2], overflow[0]}), 0);
`endif

    // Lower ch1 so its product fits again
    set_period(1, 40);
    wait_valid(100, w);
    wait_valid(100, w);
`ifndef FREQ_AVG_EN
    chk("ovf_clear_ch1", 64'(overflow[1]), 0);
    chk2("low_ch1", 64'(f(1)), 0, 1000);
    chk("ovf_ch0", 64'(overflow[0]), 0);
`endif

    // gate_sel change mid-window only affects the next window
    repeat (5) @(negedge clk);
    gate_sel = 2'd2;
    wait_valid(100, w);
    chk("sel_change_current_window", w, 15);
    wait_valid(1000, w);
    chk("sel2_window_len", w, 200);
`ifndef FREQ_AVG_EN
    chk("sel2_ch0", 64'(f(0)), 2500);
    chk("sel2_ch1", 64'(f(1)), 500);
    chk("sel2_ch2", 64'(f(2)), 1000);
    chk("sel2_ch3", 64'(f(3)), 0);
    chk("sel2_ovf", 64'(overflow), 0);
`endif

    // Reset mid-window discards the partial window
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_freq_out", 64'(freq_out), 0);
    chk("midrst_overflow", 64'(overflow), 0);
    chk("midrst_valid", 64'(freq_valid), 0);
    wait_valid(1000, w);
    chk("midrst_first_valid", w, 200);

    // 1 s gate (20000 cycles): ch1 at 5000 edges saturates the 12-bit counter
    gate_sel = 2'd0;
    set_period(1, 4);
    wait_valid(25000, w);
    chk("sel0_window_len", w, 20000);
`ifndef FREQ_AVG_EN
    chk("sel0_ch1_sat", 64'(f(1)), MAXV);
    chk("sel0_ch1_ovf", 64'(overflow[1]), 1);
    chk("sel0_ch0", 64'(f(0)), 2500);
    chk("sel0_ch2", 64'(f(2)), 1000);
    chk("sel0_ch3", 64'(f(3)), 0);
    chk("sel0_ovf_others", 64'({overflow[3:2], overflow[0]}), 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
